mux_scan: RTL and testbench
===========================

// Module: mux_scan
// PURPOSE
//   4-to-1 collector: the return path of the 1-to-4 LED demux. It multiplexes four
//   switch lines onto one output using either a manual select or an automatic
//   round-robin scan with a programmable dwell time.
//   It sits between the board switches and a single status LED/serial pin.
//   It also drives a one-hot channel indicator and a scan-wrap pulse.
// PARAMETERS
//   DWELL  default 1000  clk cycles spent on each channel in auto mode (>=1)
//   CNT_W  default 32    dwell counter width; must hold DWELL-1
// PORTS
//   clk      in   1  single system clock, all logic on rising edge
//   rst      in   1  synchronous reset, active-high
//   sw       in   4  switch inputs, asynchronous to clk (see CONFIGURATION)
//   sel_in   in   2  manual channel select, used when auto=0
//   auto     in   1  1 = auto round-robin scan, 0 = manual select
//   hold     in   1  1 = freeze current channel and dwell counter
//   out_led  out  1  registered value of the selected switch
//   select   out  2  currently selected channel (registered)
//   ch_led   out  4  one-hot of select (ch_led[select]=1)
//   wrap     out  1  one-cycle pulse when auto scan steps channel 3 -> 0
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): select=0, cnt=0, out_led=0, ch_led=4'b0001, wrap=0.
//     Reset mid-scan aborts the dwell immediately, with no partial step.
//   - Datapath: out_led <= sw_s[select], sampled every edge from the registered
//     select. sw_s is sw, or its synchronised copy (see CONFIGURATION).
//     Latency sw->out_led: 1 clk without SYNC_IN_EN, 3 clk with it.
//   - ch_led is decoded combinationally from the select register. It never shows 0 or 2+ bits.
//   - Modes are encoded by {auto,hold}:
//     MANUAL (auto=0,hold=0): select <= sel_in each edge (1-cycle latency); cnt <= 0; wrap=0.
//     FROZEN (hold=1, either auto): select and cnt hold their values; wrap=0.
//     SCAN (auto=1,hold=0):
//       - cnt < DWELL-1: cnt <= cnt+1.
//       - cnt == DWELL-1: cnt <= 0; select <= select+1, mod 4 (3 wraps to 0).
//       - wrap=1 on exactly the edge where select changes 3->0, else 0.
//   - DWELL=1: the channel advances on every SCAN edge; wrap pulses once every 4 clk.
//   - Mode changes:
//     - MANUAL->SCAN: scan starts from the current select with cnt=0.
//       The first step occurs DWELL edges later.
//     - SCAN->MANUAL: cnt is cleared and sel_in is taken on the same edge.
//     - hold asserted during SCAN and then released: the dwell resumes from the
//       frozen cnt. It is not restarted.
//   - Simultaneous events: rst overrides all. hold overrides auto and sel_in.
//   - cnt is internal, CNT_W wide. It never exceeds DWELL-1, so there is no overflow path.
// CONFIGURATION
//   SYNC_IN_EN defined:
//     - sw passes through a 2-flop synchroniser (reset to 0) before the mux.
//     - sw->out_led latency is 3 clk.
//   SYNC_IN_EN undefined:
//     - sw feeds the mux directly.
//     - Latency is 1 clk; use only with synchronous stimulus.
//   select, ch_led, wrap and cnt timing are identical in both builds.
// TESTING
//   T1 reset:
//     - rst=1 for 2 clk with sw=4'b1111.
//     - Expect out_led=0, select=0, ch_led=0001, wrap=0.
//     - After release in manual sel_in=0: out_led=1 after 1 clk (3 with SYNC_IN_EN).
//   T2 manual mux:
//     - sw=4'b0100; step sel_in through 0,1,2,3.
//     - Expect out_led = 0,0,1,0, each 1 clk after select updates.
//     - Expect ch_led = 0001,0010,0100,1000.
//   T3 auto scan with DWELL=4:
//     - auto=1 from select=0.
//     - Expect select steps 0->1->2->3->0 every 4 clk.
//     - Expect wrap high for exactly 1 clk at the 3->0 step, i.e. 16 clk after auto rose.
//   T4 hold:
//     - During SCAN with cnt=2, assert hold for 10 clk.
//     - Expect select and wrap=0 unchanged throughout.
//     - After release, the next step occurs 2 clk later.
//   T5 mode switch:
//     - In SCAN at select=2, set auto=0 with sel_in=1.
//     - Expect select=1 on the next edge.
//     - Re-enter SCAN: first step after 4 clk, to 2.
//   T6 reset mid-scan:
//     - With DWELL=4, select=3, cnt=3, assert rst.
//     - Expect select=0 and no wrap pulse on that edge.
//     - After release, the scan restarts with a full 4-clk dwell.

Source files
------------

// File: rtl/mux_scan.sv
// mux_scan: 4-to-1 switch collector, manual select or round-robin scan with a dwell time.
// Latency: sw->out_led 1 clk (3 clk when built with SYNC_IN_EN); sel_in->select 1 clk.
// Backpressure: none; free-running, every output is updated on every clk edge.
// Build option: define SYNC_IN_EN to pass sw through a 2-flop synchroniser.

module mux_scan #(
  parameter int DWELL = 1000,
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic [1:0] sel_in,
  input  logic       auto,
  input  logic       hold,
  output logic       out_led,
  output logic [1:0] select,
  output logic [3:0] ch_led,
  output logic       wrap
);

  // Operating mode decoded from {auto, hold}; hold wins over auto.
  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    FROZEN = 2'd1,
    SCAN   = 2'd2
  } mode_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [3:0]       sw_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       sel_nxt;
  logic             wrap_nxt;
  mode_t            mode;

`ifdef SYNC_IN_EN
  logic [3:0] sw_meta;
  logic [3:0] sw_sync;

  // Two-flop synchroniser: sw is asynchronous to clk in this build.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta <= 4'b0000;
      sw_sync <= 4'b0000;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  assign sw_s = sw_sync;
`else
  assign sw_s = sw;
`endif

  // Mode decode: hold freezes regardless of auto.
  always_comb begin
    mode = MANUAL;
    if (hold)
      mode = FROZEN;
    else if (auto)
      mode = SCAN;
  end

  // Next select / dwell counter / wrap pulse for the current mode.
  always_comb begin
    sel_nxt  = select;
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    unique case (mode)
      MANUAL: begin
        sel_nxt = sel_in;
        cnt_nxt = '0;
      end
      FROZEN: begin
        sel_nxt = select;
        cnt_nxt = cnt;
      end
      SCAN: begin
        if (cnt == LAST) begin
          // End of dwell: step channel; the 3->0 step raises wrap.
          cnt_nxt  = '0;
          sel_nxt  = select + 2'd1;
          wrap_nxt = (select == 2'd3);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        sel_nxt = select;
        cnt_nxt = cnt;
      end
    endcase
  end

  // Select, counter and wrap registers; reset aborts any dwell in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      select <= 2'd0;
      cnt    <= '0;
      wrap   <= 1'b0;
    end else begin
      select <= sel_nxt;
      cnt    <= cnt_nxt;
      wrap   <= wrap_nxt;
    end
  end

  // Output register samples the switch picked by the current select.
  always_ff @(posedge clk) begin
    if (rst)
      out_led <= 1'b0;
    else
      out_led <= sw_s[select];
  end

  // One-hot channel indicator, always exactly one bit set.
  always_comb begin
    ch_led = 4'b0001 << select;
  end

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: self-checking bench for mux_scan built with DWELL=4.
// Latency: out_led expectations are queued at drive time and popped when due.
// Backpressure: none; every step advances one clk edge.

module tb_mux_scan;

`ifdef SYNC_IN_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  // Cycles from a sel_in/sw change until out_led is guaranteed to reflect it.
  localparam int OUT_DLY = (LAT > 2) ? LAT : 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [1:0] sel_in;
  logic       auto;
  logic       hold;
  logic       out_led;
  logic [1:0] select;
  logic [3:0] ch_led;
  logic       wrap;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int   due;
    logic exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [3:0] sw;
    logic [1:0] sel;
    logic [1:0] exp_sel;
    logic [3:0] exp_ch;
    logic       exp_out;
  } vec_t;
  vec_t tv[5];

  mux_scan #(.DWELL(4), .CNT_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .sel_in (sel_in),
    .auto   (auto),
    .hold   (hold),
    .out_led(out_led),
    .select (select),
    .ch_led (ch_led),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, retire due scoreboard entries.
  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      chk("out_led", {31'd0, out_led}, {31'd0, e.exp});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) step();
    chk("sb_drained", sb_q.size(), 0);
  endtask

  task automatic chk_scan(input string name, input logic [1:0] es, input logic ew);
    chk({name, "_sel"}, {30'd0, select}, {30'd0, es});
    chk({name, "_wrap"}, {31'd0, wrap}, {31'd0, ew});
    chk({name, "_ch"}, {28'd0, ch_led}, {28'd0, 4'b0001 << es});
  endtask

  initial begin
    tv[0] = '{4'b0100, 2'd0, 2'd0, 4'b0001, 1'b0};
    tv[1] = '{4'b0100, 2'd1, 2'd1, 4'b0010, 1'b0};
    tv[2] = '{4'b0100, 2'd2, 2'd2, 4'b0100, 1'b1};
    tv[3] = '{4'b0100, 2'd3, 2'd3, 4'b1000, 1'b0};
    tv[4] = '{4'b1000, 2'd3, 2'd3, 4'b1000, 1'b1};

    // T1 reset
    rst = 1'b1; sw = 4'b1111; sel_in = 2'd0; auto = 1'b0; hold = 1'b0;
    step(); step();
    chk("rst_out", {31'd0, out_led}, 0);
    chk_scan("rst", 2'd0, 1'b0);
    rst = 1'b0;
    sb_q.push_back('{cyc + LAT, 1'b1});
    drain();

    // T2 manual mux, table driven
    for (int i = 0; i < 5; i++) begin
      sw = tv[i].sw;
      sel_in = tv[i].sel;
      sb_q.push_back('{cyc + OUT_DLY, tv[i].exp_out});
      step();
      chk("man_sel", {30'd0, select}, {30'd0, tv[i].exp_sel});
      chk("man_ch", {28'd0, ch_led}, {28'd0, tv[i].exp_ch});
      chk("man_wrap", {31'd0, wrap}, 0);
      step();
    end
    drain();

    // T3 auto scan from select=0
    sel_in = 2'd0;
    step();
    chk("t3_start", {30'd0, select}, 0);
    auto = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      chk_scan("t3", 2'((k / 4) % 4), k == 16);
    end

    // T4 hold with cnt=2, then resume
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk_scan("t4_hold", 2'd0, 1'b0);
    end
    hold = 1'b0;
    step();
    chk_scan("t4_rel1", 2'd0, 1'b0);
    step();
    chk_scan("t4_rel2", 2'd1, 1'b0);

    // T5 leave scan at select=2, re-enter
    repeat (4) step();
    chk("t5_at2", {30'd0, select}, 2);
    auto = 1'b0; sel_in = 2'd1;
    step();
    chk_scan("t5_man", 2'd1, 1'b0);
    auto = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_scan("t5_rescan", (k < 4) ? 2'd1 : 2'd2, 1'b0);
    end

    // T6 reset at select=3, cnt=3
    repeat (7) step();
    chk("t6_at3", {30'd0, select}, 3);
    rst = 1'b1;
    step();
    chk_scan("t6_rst", 2'd0, 1'b0);
    chk("t6_out", {31'd0, out_led}, 0);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_scan("t6_restart", (k < 4) ? 2'd0 : 2'd1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
